// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int XLEN = 32;

    // Number of consecutive data grants tolerated while a fetch is waiting.
    localparam logic [2:0] STARVE_LIMIT = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // Saturating increment for the 3-bit starvation counter.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data side normally wins, but a fetch that
// has been passed over STARVE_LIMIT times in a row is served next.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic [2:0] starve_cnt,
    output logic       winner
);

    // Winner is encoded with req_id_t values (REQ_DM / REQ_IF).
    always_comb begin
        winner = REQ_IF;
        if (if_req && (starve_cnt == STARVE_LIMIT)) begin
            winner = REQ_IF;
        end else if (dm_req) begin
            winner = REQ_DM;
        end else begin
            winner = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: merges a fetch port and a data port onto a
// single request/ack/rvalid memory interface, one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,

    input  logic            dm_req,
    input  logic [3:0]      dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_done,

    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            stall
);

    state_t          state_q, state_d;
    req_id_t         owner_q, owner_d;
    logic [2:0]      starve_cnt_q, starve_cnt_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            if_done_q, if_done_d;
    logic            dm_done_q, dm_done_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;

    logic            pick_winner;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .starve_cnt (starve_cnt_q),
        .winner     (pick_winner)
    );

    // Next-state, payload latching, read-data capture and done generation.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        if_done_d    = 1'b0;
        dm_done_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    mem_req_d = 1'b1;
                    state_d   = ADDR;
                    if (pick_winner == REQ_DM) begin
                        owner_d     = REQ_DM;
                        mem_addr_d  = dm_addr;
                        mem_we_d    = dm_we;
                        mem_wdata_d = dm_wdata;
                        if (if_req) begin
                            starve_cnt_d = sat_inc3(starve_cnt_q);
                        end
                    end else begin
                        owner_d      = REQ_IF;
                        mem_addr_d   = if_addr;
                        mem_we_d     = 4'b0000;
                        mem_wdata_d  = '0;
                        starve_cnt_d = 3'd0;
                    end
                end
            end

            ADDR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q != 4'b0000) begin
                        state_d = RESP;
                    end else if (mem_rvalid) begin
                        state_d = RESP;
                        if (owner_q == REQ_DM) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        state_d = RDATA;
                    end
                    if (state_d == RESP) begin
                        if_done_d = (owner_q == REQ_IF);
                        dm_done_d = (owner_q == REQ_DM);
                    end
                end
            end

            RDATA: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    if (owner_q == REQ_DM) begin
                        dm_rdata_d = mem_rdata;
                        dm_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= REQ_IF;
            starve_cnt_q <= 3'd0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 4'b0000;
            mem_wdata_q  <= '0;
            if_done_q    <= 1'b0;
            dm_done_q    <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            if_done_q    <= if_done_d;
            dm_done_q    <= dm_done_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // Output wiring; stall freezes the CPU while either side is waiting.
    always_comb begin
        mem_req   = mem_req_q;
        mem_addr  = mem_addr_q;
        mem_we    = mem_we_q;
        mem_wdata = mem_wdata_q;
        if_done   = if_done_q;
        dm_done   = dm_done_q;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        stall     = (if_req & ~if_done_q) | (dm_req & ~dm_done_q);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;

    int checks;
    int errors;

    mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall      (stall)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the memory-side response and let combinational outputs settle.
    task automatic applyStimulus(input logic ack, input logic rvalid, input logic [31:0] rdata);
        mem_ack    = ack;
        mem_rvalid = rvalid;
        mem_rdata  = rdata;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_req     = 1'b0;
        dm_we      = 4'b0000;
        dm_addr    = '0;
        dm_wdata   = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // ---- reset values ----
        #12;
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_done", {30'd0, if_done, dm_done}, 32'd0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // ---- single fetch, same-cycle ack+rvalid ----
        $display("[TB] single fetch");
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        #1;
        checkOutput("f_stall_c0", {31'd0, stall}, 32'd1);
        checkOutput("f_memreq_c0", {31'd0, mem_req}, 32'd0);
        nextCycle();
        checkOutput("f_memreq_c1", {31'd0, mem_req}, 32'd1);
        checkOutput("f_addr_c1", mem_addr, 32'h0000_0100);
        checkOutput("f_we_c1", {28'd0, mem_we}, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("f_done_c2", {31'd0, if_done}, 32'd1);
        checkOutput("f_rdata_c2", if_rdata, 32'hDEAD_BEEF);
        checkOutput("f_memreq_c2", {31'd0, mem_req}, 32'd0);
        checkOutput("f_stall_c2", {31'd0, stall}, 32'd0);
        nextCycle();
        if_req = 1'b0;
        #1;
        checkOutput("f_done_c3", {31'd0, if_done}, 32'd0);

        // ---- simultaneous load + fetch ----
        $display("[TB] simultaneous load and fetch");
        dm_req  = 1'b1;
        dm_we   = 4'b0000;
        dm_addr = 32'h0000_0040;
        if_req  = 1'b1;
        if_addr = 32'h0000_0008;
        #1;
        checkOutput("s_stall_c0", {31'd0, stall}, 32'd1);
        nextCycle();
        checkOutput("s_addr_c1", mem_addr, 32'h0000_0040);
        checkOutput("s_memreq_c1", {31'd0, mem_req}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h1122_3344);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("s_dmdone_c2", {31'd0, dm_done}, 32'd1);
        checkOutput("s_ifdone_c2", {31'd0, if_done}, 32'd0);
        checkOutput("s_dmrdata_c2", dm_rdata, 32'h1122_3344);
        checkOutput("s_stall_c2", {31'd0, stall}, 32'd1);
        checkOutput("s_starve_c2", {29'd0, dut.starve_cnt_q}, 32'd1);
        nextCycle();
        dm_req = 1'b0;
        #1;
        checkOutput("s_memreq_c3", {31'd0, mem_req}, 32'd0);
        checkOutput("s_stall_c3", {31'd0, stall}, 32'd1);
        nextCycle();
        checkOutput("s_memreq_c4", {31'd0, mem_req}, 32'd1);
        checkOutput("s_addr_c4", mem_addr, 32'h0000_0008);
        checkOutput("s_we_c4", {28'd0, mem_we}, 32'd0);
        checkOutput("s_stall_c4", {31'd0, stall}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h5566_7788);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("s_ifdone_c5", {31'd0, if_done}, 32'd1);
        checkOutput("s_ifrdata_c5", if_rdata, 32'h5566_7788);
        checkOutput("s_stall_c5", {31'd0, stall}, 32'd0);
        checkOutput("s_starve_c5", {29'd0, dut.starve_cnt_q}, 32'd0);
        nextCycle();
        if_req = 1'b0;
        #1;

        // ---- store with ack delayed 3 cycles ----
        $display("[TB] delayed store");
        dm_req   = 1'b1;
        dm_we    = 4'b0011;
        dm_addr  = 32'h0000_2000;
        dm_wdata = 32'h1234_ABCD;
        nextCycle();
        for (int c = 1; c <= 4; c++) begin
            checkOutput("st_memreq", {31'd0, mem_req}, 32'd1);
            checkOutput("st_addr", mem_addr, 32'h0000_2000);
            checkOutput("st_we", {28'd0, mem_we}, 32'h3);
            checkOutput("st_wdata", mem_wdata, 32'h1234_ABCD);
            checkOutput("st_nodone", {31'd0, dm_done}, 32'd0);
            if (c == 4) begin
                applyStimulus(1'b1, 1'b1, 32'h0BAD_0BAD);
            end
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("st_done", {31'd0, dm_done}, 32'd1);
        checkOutput("st_memreq_after", {31'd0, mem_req}, 32'd0);
        checkOutput("st_dmrdata_kept", dm_rdata, 32'h1122_3344);
        nextCycle();
        dm_req = 1'b0;
        dm_we  = 4'b0000;
        #1;
        checkOutput("st_done_clear", {31'd0, dm_done}, 32'd0);

        // ---- split read: ack at cycle 1, rvalid at cycle 5 ----
        $display("[TB] split read");
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0300;
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("sp_memreq_c2", {31'd0, mem_req}, 32'd0);
        for (int c = 2; c <= 5; c++) begin
            checkOutput("sp_state_rdata", 32'(dut.state_q), 32'(RDATA));
            checkOutput("sp_nodone", {31'd0, dm_done}, 32'd0);
            if (c == 5) begin
                applyStimulus(1'b0, 1'b1, 32'hA5A5_5A5A);
            end
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("sp_done_c6", {31'd0, dm_done}, 32'd1);
        checkOutput("sp_rdata_c6", dm_rdata, 32'hA5A5_5A5A);
        nextCycle();
        dm_req = 1'b0;
        #1;
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("sp_spur_dmrdata", dm_rdata, 32'hA5A5_5A5A);
        checkOutput("sp_spur_ifrdata", if_rdata, 32'h5566_7788);
        checkOutput("sp_spur_state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("sp_spur_done", {30'd0, if_done, dm_done}, 32'd0);
        checkOutput("sp_spur_memreq", {31'd0, mem_req}, 32'd0);

        // ---- starvation: fetch forced through after 4 data grants ----
        $display("[TB] starvation");
        if_req  = 1'b1;
        if_addr = 32'h0000_0500;
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0600;
        for (int g = 1; g <= 5; g++) begin
            nextCycle();
            checkOutput("sv_addr", mem_addr, (g <= 4) ? 32'h0000_0600 : 32'h0000_0500);
            checkOutput("sv_stall", {31'd0, stall}, 32'd1);
            applyStimulus(1'b1, 1'b1, 32'h0000_1000 + 32'(g));
            nextCycle();
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("sv_dmdone", {31'd0, dm_done}, (g <= 4) ? 32'd1 : 32'd0);
            checkOutput("sv_ifdone", {31'd0, if_done}, (g <= 4) ? 32'd0 : 32'd1);
            checkOutput("sv_starve", {29'd0, dut.starve_cnt_q}, (g <= 4) ? 32'(g) : 32'd0);
            nextCycle();
            if (g == 5) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            #1;
        end
        checkOutput("sv_ifrdata", if_rdata, 32'h0000_1005);
        checkOutput("sv_dmrdata", dm_rdata, 32'h0000_1004);

        // ---- reset while waiting in RDATA ----
        $display("[TB] reset in RDATA");
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0700;
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rr_state_rdata", 32'(dut.state_q), 32'(RDATA));
        rst_n  = 1'b0;
        dm_req = 1'b0;
        #1;
        checkOutput("rr_state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("rr_memreq", {31'd0, mem_req}, 32'd0);
        checkOutput("rr_addr", mem_addr, 32'd0);
        checkOutput("rr_we", {28'd0, mem_we}, 32'd0);
        checkOutput("rr_wdata", mem_wdata, 32'd0);
        checkOutput("rr_rdata", if_rdata | dm_rdata, 32'd0);
        checkOutput("rr_starve", {29'd0, dut.starve_cnt_q}, 32'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h0000_0077);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rr_late_done", {30'd0, if_done, dm_done}, 32'd0);
        checkOutput("rr_late_rdata", dm_rdata, 32'd0);
        checkOutput("rr_late_memreq", {31'd0, mem_req}, 32'd0);
        if_req  = 1'b1;
        if_addr = 32'h0000_0900;
        nextCycle();
        checkOutput("rr_next_memreq", {31'd0, mem_req}, 32'd1);
        checkOutput("rr_next_addr", mem_addr, 32'h0000_0900);
        applyStimulus(1'b1, 1'b1, 32'h9999_0000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rr_next_done", {31'd0, if_done}, 32'd1);
        checkOutput("rr_next_rdata", if_rdata, 32'h9999_0000);
        nextCycle();
        if_req = 1'b0;
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-002 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address
- if_rdata  out  32  fetch data, valid with if_done
- if_done  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, held until dm_done
- dm_we  in  4  byte write mask; 4'b0000 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid with dm_done
- dm_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request
- mem_addr  out  32  memory address
- mem_we  out  4  memory byte write mask
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory accepted request (a write is complete at ack)
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- stall  out  1  CPU freeze
REQ-003 Requesters SHALL hold req, address, mask and data stable from assertion until the cycle after their done pulse.

Function
REQ-004 The FSM SHALL have four states: IDLE, ADDR, RDATA and RESP.
REQ-005 IDLE: if any request is pending, the block SHALL choose a winner, register its addr/we/wdata onto mem_*, set mem_req=1 and go to ADDR; with no request it SHALL stay in IDLE with mem_req=0.
REQ-006 Priority SHALL go to data over fetch, except when starve_cnt equals STARVE_LIMIT (4); then fetch wins.
REQ-007 starve_cnt (3-bit, saturating) SHALL be handled as follows:
- increment when dm wins while if_req=1
- clear when if wins
- hold otherwise
REQ-008 ADDR: mem_req and the mem_* payload SHALL stay constant until mem_ack=1.
REQ-009 On ack, the next state SHALL be:
- RESP for a write (mem_we!=0)
- RESP for a read with mem_rvalid=1 in the same cycle, capturing mem_rdata
- RDATA for a read otherwise
REQ-010 mem_req SHALL deassert in the cycle after ack.
REQ-011 RDATA: the block SHALL wait for mem_rvalid, capture mem_rdata into the winner's rdata register, then go to RESP.
REQ-012 RESP: the winner's done output SHALL be 1 for exactly this cycle; no arbitration SHALL occur in RESP; the next state SHALL be IDLE.
REQ-013 if_rdata and dm_rdata SHALL be registered and hold their value until the next capture for the same requester.
REQ-014 dm_rdata SHALL be unchanged after a store.
REQ-015 stall SHALL be combinational: (if_req & ~if_done) | (dm_req & ~dm_done).
REQ-016 Minimum latency SHALL be 2 cycles: request seen in IDLE at cycle 0, ack+rvalid at cycle 1, done at cycle 2.
REQ-017 mem_ack outside ADDR and mem_rvalid outside ADDR/RDATA SHALL be ignored.
REQ-018 When dm_req and if_req arrive in the same cycle, the requests SHALL be served back-to-back: data first, then fetch starting from IDLE after RESP.
REQ-019 mem_we SHALL be 0 for every fetch transaction.

Reset
REQ-020 While rst_n=0, the block SHALL force the following, asynchronously:
- state=IDLE
- starve_cnt=0
- mem_req=0
- mem_addr=0, mem_we=0, mem_wdata=0
- if_done=0, dm_done=0
- if_rdata=0, dm_rdata=0
REQ-021 On reset mid-transaction, the in-flight access SHALL be abandoned: no done pulse, and late mem_ack/mem_rvalid SHALL be ignored.

Structure
REQ-022 Package mem_arb_pkg SHALL hold:
- state enum type
- requester-id type (IF/DM)
- STARVE_LIMIT=4
- XLEN=32
REQ-023 The priority/starvation pick SHALL be a combinational sub-module mem_arb_pick with inputs if_req, dm_req, starve_cnt and output winner.
REQ-024 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-025 The bench SHALL cover a single fetch: if_req=1 at if_addr=0x100; memory acks and returns 0xDEADBEEF in the same cycle -> if_done at cycle 2, if_rdata=0xDEADBEEF, mem_we=0.
REQ-026 The bench SHALL cover a store: dm_we=4'b0011 at dm_addr=0x2000 with 0x1234ABCD, ack delayed 3 cycles -> mem_req held for 4 cycles with a stable payload, dm_done one cycle after ack, dm_rdata unchanged.
REQ-027 The bench SHALL cover a simultaneous request: a load at 0x40 and a fetch at 0x8, both at cycle 0 -> load served first, fetch mem_req appearing after RESP, stall=1 until if_done.
REQ-028 The bench SHALL cover starvation: if_req held with dm_req continuously reasserted -> after 4 data grants the 5th grant goes to fetch and starve_cnt returns to 0.
REQ-029 The bench SHALL cover split read: ack at cycle 1, rvalid at cycle 5 -> state RDATA for cycles 2-5, done at cycle 6, and a spurious rvalid in IDLE changing nothing.
REQ-030 The bench SHALL cover reset in RDATA: rst_n low for 1 cycle, then rvalid -> no done pulse, all outputs 0, next request arbitrated normally.
